minigame_fsm_nway: RTL and testbench
====================================

Name: minigame_fsm_nway

Overview:
Parametrised next-generation minigame controller for the camera/VGA overlay path. It supports N target regions, a configurable number of rounds, frame-based timers and a per-round shrinking play window. Region selection is pseudo-random and never repeats back-to-back. It takes per-region colour-detect flags from the colour detectors, frames its timing on vsync, and drives the overlay with state, target, result and score.

Parameters:
N_REGIONS, 4, number of target regions (2..16).
N_ROUNDS, 5, rounds per game (1..15).
READY_FRAMES, 60, length of READY in frames.
SKIP_FRAMES, 4, frames ignored at PLAY entry.
PLAY_FRAMES, 120, round-0 play window in frames.
DECAY_FRAMES, 10, window reduction per round.
MIN_PLAY_FRAMES, 60, floor of the play window.
HOLD_FRAMES, 45, consecutive correct frames required for success.
END_FRAMES, 60, length of ROUND_END in frames.
SCORE_FRAMES, 300, length of SCOREBOARD in frames.
LFSR_SEED, 8'hA5, non-zero 8-bit LFSR seed.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  level; accepted only in IDLE
abort  in  1  level; forces IDLE from any state
vsync  in  1  VGA vsync, synchronous to clk
detect  in  N_REGIONS  per-region detect flags, bit i = region i
fsm_state  out  3  IDLE=0 READY=1 PLAY=2 ROUND_END=3 SCOREBOARD=4
region  out  RW=$clog2(N_REGIONS)  current target
result_type  out  2  NONE=0 SUCCESS=1 FAIL=2
round_cnt  out  CW=$clog2(N_ROUNDS)  current round index (minimum width 1)
score  out  SW=$clog2(2*N_ROUNDS+1)  accumulated score
round_result  out  N_ROUNDS  bit r = round r succeeded
streak  out  CW+1  consecutive successes (0 unless combo enabled)
done  out  1  one-clk pulse when SCOREBOARD exits

Behaviour:
- Reset values: all outputs 0; state IDLE; LFSR = LFSR_SEED; all timers 0.
- tick: vsync rising edge, registered, so it asserts one clk after the edge. All timers count ticks. detect is captured into detect_d on each tick.
- correct = (detect_d == one-hot(region)). Multiple or zero flags are never correct.
- LFSR: 8-bit Fibonacci, taps mask 8'hB8, advances on every tick in every state.
- IDLE:
  - On start, go to READY next clk.
  - Clear score, round_result, round_cnt, streak and timers; set result_type=NONE.
  - Previous results stay visible in IDLE until start.
- READY:
  - On the tick where ready_cnt==READY_FRAMES-1, go to PLAY.
  - On that tick: latch region = pick(lfsr). pick = lfsr % N_REGIONS; if that equals the previous region, use (value+1) % N_REGIONS. Round 0 has no previous region.
  - Also latch play_limit = max(PLAY_FRAMES - round_cnt*DECAY_FRAMES, MIN_PLAY_FRAMES), computed signed with no underflow.
  - Clear hold_cnt and play_cnt.
- PLAY:
  - The first SKIP_FRAMES ticks only decrement the skip counter.
  - Each later tick: play_cnt++; hold_cnt = correct ? hold_cnt+1 : 0.
  - Success: correct && hold_cnt==HOLD_FRAMES-1 → SUCCESS, score+1, round_result[round_cnt]=1, go to ROUND_END.
  - Timeout: play_cnt==play_limit-1 without success → FAIL, bit stays 0, go to ROUND_END.
  - If both occur on the same tick, success wins.
- ROUND_END:
  - On the tick where end_cnt==END_FRAMES-1: if round_cnt==N_ROUNDS-1, go to SCOREBOARD.
  - Otherwise round_cnt++, result_type=NONE, go to READY.
- SCOREBOARD: on the tick where score_cnt==SCORE_FRAMES-1, go to IDLE and pulse done for one clk.
- abort:
  - Highest priority: IDLE on the next clk from any state.
  - Timers clear and result_type=NONE.
  - score and round_result are retained; done is not pulsed.
- start outside IDLE is ignored. start and abort together in IDLE: abort wins and the FSM stays in IDLE.
- Timer widths are sized from their parameters. Counters never wrap because the state always exits at the terminal count.

Optional Feature:
MINIGAME_COMBO_EN:
- Defined:
  - streak increments on SUCCESS and clears on FAIL and at game start.
  - A SUCCESS while streak (before increment) ≥2 adds 2 to score instead of 1.
  - A saturating adder caps score at 2*N_ROUNDS.
- Undefined: streak is tied to 0 and every success adds 1.

Decomposition:
- minigame_pkg holds state_t, result_t, the encodings above, and the LFSR tap-mask constant.
- One sub-module, minigame_region_picker, holds the LFSR, the modulo reduction, the no-repeat rule and the previous-region register.
  - Interface: clk, reset_n, tick, load, first → region.

Test Plan:
Test parameters: N_REGIONS=4, N_ROUNDS=3, READY=2, SKIP=1, PLAY=10, DECAY=2, MIN=6, HOLD=3, END=2, SCORE=3.
1. start, then hold detect=one-hot(region) every frame → each round SUCCESS on the 4th PLAY tick; final score=3, round_result=3'b111; done pulses once after 3 SCOREBOARD ticks.
2. detect=0 throughout → play windows of 10, 8, 6 ticks after skip; all FAIL; score=0, round_result=0.
3. Correct for 2 frames, 1 wrong frame, then correct → hold restarts; SUCCESS 3 ticks after the wrong frame; two flags set never counts as correct.
4. Correct for HOLD frames with the hold terminal count landing on the timeout tick → SUCCESS, not FAIL.
5. abort asserted mid-PLAY in round 1 → IDLE next clk; score kept; no done pulse; a new start clears score.
6. Run 200 rounds across games → region never equals the previous round's region within a game, and every value in 0..3 occurs.

Source files
------------

// File: rtl/minigame_pkg.sv
// Shared types and constants for the N-way minigame controller.
// The optional combo scoring (MINIGAME_COMBO_EN) is selected in the top module.
package minigame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READY      = 3'd1,
    ST_PLAY       = 3'd2,
    ST_ROUND_END  = 3'd3,
    ST_SCOREBOARD = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_SUCCESS = 2'd1,
    RES_FAIL    = 2'd2
  } result_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/minigame_region_picker.sv
// Pseudo-random target picker: free-running 8-bit LFSR, modulo reduction,
// and a no-back-to-back-repeat rule against the previously chosen region.
module minigame_region_picker
  import minigame_pkg::*;
#(
  parameter int          N_REGIONS = 4,
  parameter logic [7:0]  LFSR_SEED = 8'hA5,
  localparam int         RW        = cntWidth(N_REGIONS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          load,
  input  logic          first,
  output logic [RW-1:0] region
);

  logic [7:0]    lfsr_q, lfsr_d;
  logic [RW-1:0] region_q, region_d;
  logic [RW-1:0] pickRaw, pickAlt;

  assign pickRaw = RW'(32'(lfsr_q) % N_REGIONS);
  assign pickAlt = (pickRaw == RW'(N_REGIONS - 1)) ? '0 : pickRaw + RW'(1);

  // Round 0 has no predecessor, so the repeat rule is skipped there.
  always_comb begin
    lfsr_d   = lfsr_q;
    region_d = region_q;
    if (tick) begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
    if (load) begin
      region_d = (!first && (pickRaw == region_q)) ? pickAlt : pickRaw;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q   <= LFSR_SEED;
      region_q <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      region_q <= region_d;
    end
  end

  assign region = region_q;

endmodule

// File: rtl/minigame_fsm_nway.sv
// N-way minigame controller: vsync-framed READY/PLAY/ROUND_END/SCOREBOARD flow.
// Define MINIGAME_COMBO_EN to enable streak tracking and bonus scoring.
module minigame_fsm_nway
  import minigame_pkg::*;
#(
  parameter int         N_REGIONS       = 4,
  parameter int         N_ROUNDS        = 5,
  parameter int         READY_FRAMES    = 60,
  parameter int         SKIP_FRAMES     = 4,
  parameter int         PLAY_FRAMES     = 120,
  parameter int         DECAY_FRAMES    = 10,
  parameter int         MIN_PLAY_FRAMES = 60,
  parameter int         HOLD_FRAMES     = 45,
  parameter int         END_FRAMES      = 60,
  parameter int         SCORE_FRAMES    = 300,
  parameter logic [7:0] LFSR_SEED       = 8'hA5,
  localparam int        RW              = cntWidth(N_REGIONS),
  localparam int        CW              = cntWidth(N_ROUNDS),
  localparam int        SW              = $clog2(2 * N_ROUNDS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 vsync,
  input  logic [N_REGIONS-1:0] detect,
  output logic [2:0]           fsm_state,
  output logic [RW-1:0]        region,
  output logic [1:0]           result_type,
  output logic [CW-1:0]        round_cnt,
  output logic [SW-1:0]        score,
  output logic [N_ROUNDS-1:0]  round_result,
  output logic [CW:0]          streak,
  output logic                 done
);

  localparam int PMAX = (PLAY_FRAMES > MIN_PLAY_FRAMES) ? PLAY_FRAMES : MIN_PLAY_FRAMES;
  localparam int RDW  = cntWidth(READY_FRAMES);
  localparam int SKW  = cntWidth(SKIP_FRAMES + 1);
  localparam int PW   = cntWidth(PMAX + 1);
  localparam int HW   = cntWidth(HOLD_FRAMES);
  localparam int EW   = cntWidth(END_FRAMES);
  localparam int SCW  = cntWidth(SCORE_FRAMES);

  state_t               state_q, state_d;
  result_t              result_q, result_d;
  logic                 vsyncPrev_q, tick_q;
  logic [N_REGIONS-1:0] detectSample_q;
  logic [RDW-1:0]       readyCnt_q, readyCnt_d;
  logic [SKW-1:0]       skipCnt_q, skipCnt_d;
  logic [PW-1:0]        playCnt_q, playCnt_d;
  logic [PW-1:0]        playLimit_q, playLimit_d;
  logic [HW-1:0]        holdCnt_q, holdCnt_d;
  logic [EW-1:0]        endCnt_q, endCnt_d;
  logic [SCW-1:0]       scoreCnt_q, scoreCnt_d;
  logic [CW-1:0]        roundCnt_q, roundCnt_d;
  logic [SW-1:0]        score_q, score_d, scoreNext;
  logic [N_ROUNDS-1:0]  roundResult_q, roundResult_d;
  logic [CW:0]          streak_q, streak_d, streakNext;
  logic                 done_q, done_d;
  logic                 pickLoad, correct;
  logic [N_REGIONS-1:0] targetMask;
  int                   limitCalc;

  // Detect flags are sampled on the same edge that raises tick, so the
  // sample seen by the FSM belongs to the frame being counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsyncPrev_q    <= 1'b0;
      tick_q         <= 1'b0;
      detectSample_q <= '0;
    end else begin
      vsyncPrev_q <= vsync;
      tick_q      <= vsync & ~vsyncPrev_q;
      if (vsync && !vsyncPrev_q) begin
        detectSample_q <= detect;
      end
    end
  end

  minigame_region_picker #(
    .N_REGIONS (N_REGIONS),
    .LFSR_SEED (LFSR_SEED)
  ) u_picker (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick_q),
    .load    (pickLoad),
    .first   (roundCnt_q == '0),
    .region  (region)
  );

  assign targetMask = N_REGIONS'(1) << region;
  assign correct    = (detectSample_q == targetMask);

  always_comb begin
    limitCalc = PLAY_FRAMES - int'(roundCnt_q) * DECAY_FRAMES;
    if (limitCalc < MIN_PLAY_FRAMES) begin
      limitCalc = MIN_PLAY_FRAMES;
    end
  end

`ifdef MINIGAME_COMBO_EN
  logic [SW:0] scoreSum;
  assign scoreSum   = {1'b0, score_q} +
                      ((streak_q >= (CW + 1)'(2)) ? (SW + 1)'(2) : (SW + 1)'(1));
  assign scoreNext  = (scoreSum > (SW + 1)'(2 * N_ROUNDS)) ? SW'(2 * N_ROUNDS)
                                                           : scoreSum[SW-1:0];
  assign streakNext = streak_q + (CW + 1)'(1);
`else
  assign scoreNext  = score_q + SW'(1);
  assign streakNext = '0;
`endif

  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    readyCnt_d    = readyCnt_q;
    skipCnt_d     = skipCnt_q;
    playCnt_d     = playCnt_q;
    playLimit_d   = playLimit_q;
    holdCnt_d     = holdCnt_q;
    endCnt_d      = endCnt_q;
    scoreCnt_d    = scoreCnt_q;
    roundCnt_d    = roundCnt_q;
    score_d       = score_q;
    roundResult_d = roundResult_q;
    streak_d      = streak_q;
    done_d        = 1'b0;
    pickLoad      = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      result_d    = RES_NONE;
      readyCnt_d  = '0;
      skipCnt_d   = '0;
      playCnt_d   = '0;
      playLimit_d = '0;
      holdCnt_d   = '0;
      endCnt_d    = '0;
      scoreCnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d       = ST_READY;
            result_d      = RES_NONE;
            score_d       = '0;
            roundResult_d = '0;
            roundCnt_d    = '0;
            streak_d      = '0;
            readyCnt_d    = '0;
            skipCnt_d     = '0;
            playCnt_d     = '0;
            playLimit_d   = '0;
            holdCnt_d     = '0;
            endCnt_d      = '0;
            scoreCnt_d    = '0;
          end
        end
        ST_READY: begin
          if (tick_q) begin
            if (readyCnt_q == RDW'(READY_FRAMES - 1)) begin
              state_d     = ST_PLAY;
              readyCnt_d  = '0;
              pickLoad    = 1'b1;
              playLimit_d = PW'(limitCalc);
              playCnt_d   = '0;
              holdCnt_d   = '0;
              skipCnt_d   = SKW'(SKIP_FRAMES);
            end else begin
              readyCnt_d = readyCnt_q + RDW'(1);
            end
          end
        end
        ST_PLAY: begin
          if (tick_q) begin
            if (skipCnt_q != '0) begin
              skipCnt_d = skipCnt_q - SKW'(1);
            end else begin
              playCnt_d = playCnt_q + PW'(1);
              holdCnt_d = correct ? holdCnt_q + HW'(1) : '0;
              // Success is tested first so it wins over a same-tick timeout.
              if (correct && (holdCnt_q == HW'(HOLD_FRAMES - 1))) begin
                state_d                   = ST_ROUND_END;
                result_d                  = RES_SUCCESS;
                score_d                   = scoreNext;
                roundResult_d[roundCnt_q] = 1'b1;
                streak_d                  = streakNext;
                endCnt_d                  = '0;
              end else if (playCnt_q == playLimit_q - PW'(1)) begin
                state_d  = ST_ROUND_END;
                result_d = RES_FAIL;
                streak_d = '0;
                endCnt_d = '0;
              end
            end
          end
        end
        ST_ROUND_END: begin
          if (tick_q) begin
            if (endCnt_q == EW'(END_FRAMES - 1)) begin
              endCnt_d = '0;
              if (roundCnt_q == CW'(N_ROUNDS - 1)) begin
                state_d    = ST_SCOREBOARD;
                scoreCnt_d = '0;
              end else begin
                state_d    = ST_READY;
                roundCnt_d = roundCnt_q + CW'(1);
                result_d   = RES_NONE;
                readyCnt_d = '0;
              end
            end else begin
              endCnt_d = endCnt_q + EW'(1);
            end
          end
        end
        ST_SCOREBOARD: begin
          if (tick_q) begin
            if (scoreCnt_q == SCW'(SCORE_FRAMES - 1)) begin
              state_d    = ST_IDLE;
              scoreCnt_d = '0;
              done_d     = 1'b1;
            end else begin
              scoreCnt_d = scoreCnt_q + SCW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      result_q      <= RES_NONE;
      readyCnt_q    <= '0;
      skipCnt_q     <= '0;
      playCnt_q     <= '0;
      playLimit_q   <= '0;
      holdCnt_q     <= '0;
      endCnt_q      <= '0;
      scoreCnt_q    <= '0;
      roundCnt_q    <= '0;
      score_q       <= '0;
      roundResult_q <= '0;
      streak_q      <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      readyCnt_q    <= readyCnt_d;
      skipCnt_q     <= skipCnt_d;
      playCnt_q     <= playCnt_d;
      playLimit_q   <= playLimit_d;
      holdCnt_q     <= holdCnt_d;
      endCnt_q      <= endCnt_d;
      scoreCnt_q    <= scoreCnt_d;
      roundCnt_q    <= roundCnt_d;
      score_q       <= score_d;
      roundResult_q <= roundResult_d;
      streak_q      <= streak_d;
      done_q        <= done_d;
    end
  end

  assign fsm_state    = state_q;
  assign result_type  = result_q;
  assign round_cnt    = roundCnt_q;
  assign score        = score_q;
  assign round_result = roundResult_q;
  assign streak       = streak_q;
  assign done         = done_q;

endmodule

// File: tb/tb_minigame_fsm_nway.sv
// Directed testbench for minigame_fsm_nway with shortened frame parameters.
// Expectations follow MINIGAME_COMBO_EN when it is defined for the build.
module tb_minigame_fsm_nway;

  localparam int NRND = 3;

  logic       clk = 1'b0;
  logic       reset_n, start, abort, vsync;
  logic [3:0] detect;
  logic [2:0] fsm_state;
  logic [1:0] region;
  logic [1:0] result_type;
  logic [1:0] round_cnt;
  logic [2:0] score;
  logic [2:0] round_result;
  logic [2:0] streak;
  logic       done;

  int         checks = 0;
  int         failures = 0;
  int         doneCount = 0;
  int         prevRegion = 0;
  int         expScore = 0;
  int         expStreak = 0;
  int         roundsRun = 0;
  logic [2:0] expRR = '0;
  logic [3:0] seenRegions = '0;
  logic [7:0] lfsrModel, lfsrAtTick;
  int         limits[NRND] = '{10, 8, 6};

  minigame_fsm_nway #(
    .N_REGIONS(4), .N_ROUNDS(NRND), .READY_FRAMES(2), .SKIP_FRAMES(1),
    .PLAY_FRAMES(10), .DECAY_FRAMES(2), .MIN_PLAY_FRAMES(6), .HOLD_FRAMES(3),
    .END_FRAMES(2), .SCORE_FRAMES(3), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .vsync(vsync),
    .detect(detect), .fsm_state(fsm_state), .region(region),
    .result_type(result_type), .round_cnt(round_cnt), .score(score),
    .round_result(round_result), .streak(streak), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One video frame: a vsync pulse, with the reference LFSR stepped in lockstep.
  task automatic applyStimulus(input logic [3:0] det);
    detect = det;
    @(negedge clk);
    vsync      = 1'b1;
    lfsrAtTick = lfsrModel;
    lfsrModel  = {lfsrModel[6:0], ^(lfsrModel & 8'hB8)};
    @(negedge clk);
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] oneHot(input int r);
    return 4'b0001 << r;
  endfunction

  function automatic int pickModel(input logic [7:0] l, input int prev, input bit first);
    int v;
    v = int'(l) % 4;
    if (!first && v == prev) v = (v + 1) % 4;
    return v;
  endfunction

  // kind 0: always correct; 1: never; 2: double-flag glitch on tick 3; 3: correct only at window tail
  function automatic logic [3:0] detectFor(input int kind, input int k, input int r, input int limit);
    case (kind)
      0:       return oneHot(r);
      1:       return 4'b0000;
      2:       return (k == 3) ? (oneHot(r) | oneHot((r + 1) % 4)) : oneHot(r);
      default: return (k >= limit - 2) ? oneHot(r) : 4'b0000;
    endcase
  endfunction

  task automatic startGame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_ready", fsm_state, 1);
    checkOutput("start_clear_score", score, 0);
    checkOutput("start_clear_rr", round_result, 0);
    checkOutput("start_clear_result", result_type, 0);
    expScore  = 0;
    expStreak = 0;
    expRR     = '0;
  endtask

  task automatic runRound(input int r, input int kind, input int expExit, input logic [1:0] expRes);
    int exitK;
    int expReg;
    int limit;
    limit = limits[r];
    applyStimulus(4'b0000);
    checkOutput("ready_hold", fsm_state, 1);
    applyStimulus(4'b0000);
    checkOutput("enter_play", fsm_state, 2);
    expReg = pickModel(lfsrAtTick, prevRegion, r == 0);
    checkOutput("region", region, expReg);
    if (r != 0) checkOutput("no_repeat", region == 2'(prevRegion), 0);
    seenRegions[region] = 1'b1;
    prevRegion = expReg;
    applyStimulus(detectFor(kind, 0, expReg, limit));
    checkOutput("skip_play", fsm_state, 2);
    exitK = 0;
    for (int k = 1; k <= limit + 1; k++) begin
      applyStimulus(detectFor(kind, k, expReg, limit));
      if (fsm_state != 3'd2) begin
        exitK = k;
        break;
      end
    end
    checkOutput("exit_tick", exitK, expExit);
    checkOutput("result", result_type, expRes);
    if (expRes == 2'd1) begin
`ifdef MINIGAME_COMBO_EN
      expScore += (expStreak >= 2) ? 2 : 1;
      if (expScore > 2 * NRND) expScore = 2 * NRND;
      expStreak++;
`else
      expScore += 1;
`endif
      expRR[r] = 1'b1;
    end else begin
      expStreak = 0;
    end
    checkOutput("score", score, expScore);
    checkOutput("round_result", round_result, expRR);
    checkOutput("streak", streak, expStreak);
    applyStimulus(4'b0000);
    checkOutput("end_hold", fsm_state, 3);
    applyStimulus(4'b0000);
    if (r < NRND - 1) begin
      checkOutput("next_ready", fsm_state, 1);
      checkOutput("result_clear", result_type, 0);
      checkOutput("round_cnt", round_cnt, r + 1);
    end else begin
      checkOutput("to_scoreboard", fsm_state, 4);
    end
    roundsRun++;
  endtask

  task automatic finishGame();
    int doneBefore;
    doneBefore = doneCount;
    applyStimulus(4'b0000);
    checkOutput("scoreboard_1", fsm_state, 4);
    applyStimulus(4'b0000);
    checkOutput("scoreboard_2", fsm_state, 4);
    checkOutput("no_early_done", doneCount - doneBefore, 0);
    applyStimulus(4'b0000);
    checkOutput("game_over_idle", fsm_state, 0);
    checkOutput("done_pulses", doneCount - doneBefore, 1);
    checkOutput("final_score", score, expScore);
    checkOutput("final_rr", round_result, expRR);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int doneBefore;
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    vsync     = 1'b0;
    detect    = 4'b0000;
    lfsrModel = 8'hA5;
    repeat (3) @(negedge clk);
    checkOutput("rst_state", fsm_state, 0);
    checkOutput("rst_region", region, 0);
    checkOutput("rst_result", result_type, 0);
    checkOutput("rst_round", round_cnt, 0);
    checkOutput("rst_score", score, 0);
    checkOutput("rst_rr", round_result, 0);
    checkOutput("rst_streak", streak, 0);
    checkOutput("rst_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus(4'b0000);
    checkOutput("idle_ignores_tick", fsm_state, 0);

    $display("[TB] all-correct game");
    startGame();
    for (int r = 0; r < NRND; r++) runRound(r, 0, 3, 2'd1);
    finishGame();

    $display("[TB] all-timeout game");
    startGame();
    for (int r = 0; r < NRND; r++) runRound(r, 1, limits[r], 2'd2);
    finishGame();

    $display("[TB] hold restart and success-on-timeout game");
    startGame();
    runRound(0, 2, 6, 2'd1);
    runRound(1, 1, 8, 2'd2);
    runRound(2, 3, 6, 2'd1);
    finishGame();

    $display("[TB] abort game");
    startGame();
    runRound(0, 0, 3, 2'd1);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    checkOutput("abort_pre_play", fsm_state, 2);
    applyStimulus(oneHot(int'(region)));
    applyStimulus(oneHot(int'(region)));
    doneBefore = doneCount;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_idle", fsm_state, 0);
    checkOutput("abort_score_kept", score, expScore);
    checkOutput("abort_rr_kept", round_result, expRR);
    checkOutput("abort_result_none", result_type, 0);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);
    checkOutput("abort_stays_idle", fsm_state, 0);
    checkOutput("abort_no_done", doneCount - doneBefore, 0);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort_beats_start", fsm_state, 0);
    checkOutput("abort_start_keeps_score", score, expScore);
    startGame();
    for (int r = 0; r < NRND; r++) runRound(r, 0, 3, 2'd1);
    finishGame();

    $display("[TB] region sequence soak");
    while (roundsRun < 200) begin
      startGame();
      for (int r = 0; r < NRND; r++) runRound(r, 0, 3, 2'd1);
      finishGame();
    end
    checkOutput("region_coverage", seenRegions, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
